// File: rtl/mbox_arb_pkg.sv
// Shared types and defaults for the MBOX cycle arbiter.
//   tMboxCycType  : cycle owner encoding, MB=0 CHAN=1 CCA=2 EBOX=3
//   tMboxArbState : arbiter FSM states
package mbox_arb_pkg;

    localparam int STARVE_LIMIT_DEF   = 4;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        CYC_MB   = 2'd0,
        CYC_CHAN = 2'd1,
        CYC_CCA  = 2'd2,
        CYC_EBOX = 2'd3
    } tMboxCycType;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tMboxArbState;

endpackage

// File: rtl/mbox_cyc_arb_if.sv
// Request/grant bundle between the requesters, the CSH sequencer and the
// MBOX cycle arbiter.
//   master : requester/CSH side (drives requests, cyc_done, err_clr)
//   slave  : arbiter side (drives grants and status)
interface mbox_cyc_arb_if
    import mbox_arb_pkg::*;
();

    logic        mb_req;
    logic        chan_req;
    logic        cca_req;
    logic        ebox_req;
    logic        cyc_done;
    logic        err_clr;
    logic        mb_grant;
    logic        chan_grant;
    logic        cca_grant;
    logic        ebox_grant;
    logic        cyc_active;
    tMboxCycType cyc_type;
    logic        starve_boost;
    logic        timeout_err;

    modport master (
        output mb_req, chan_req, cca_req, ebox_req, cyc_done, err_clr,
        input  mb_grant, chan_grant, cca_grant, ebox_grant,
        input  cyc_active, cyc_type, starve_boost, timeout_err
    );

    modport slave (
        input  mb_req, chan_req, cca_req, ebox_req, cyc_done, err_clr,
        output mb_grant, chan_grant, cca_grant, ebox_grant,
        output cyc_active, cyc_type, starve_boost, timeout_err
    );

endinterface

// File: rtl/mbox_arb_prio.sv
// Combinational priority resolver for the MBOX cycle arbiter.
//   mb_req..ebox_req : level requests
//   boost            : promote EBOX just below MB
//   win              : one-hot winner, bit0 MB, bit1 CHAN, bit2 CCA, bit3 EBOX
//   win_type         : winner as tMboxCycType (don't-care when win is zero)
module mbox_arb_prio
    import mbox_arb_pkg::*;
(
    input  logic        mb_req,
    input  logic        chan_req,
    input  logic        cca_req,
    input  logic        ebox_req,
    input  logic        boost,
    output logic [3:0]  win,
    output tMboxCycType win_type
);

    always_comb begin
        win      = 4'b0000;
        win_type = CYC_MB;
        if (mb_req) begin
            win      = 4'b0001;
            win_type = CYC_MB;
        end else if (boost && ebox_req) begin
            win      = 4'b1000;
            win_type = CYC_EBOX;
        end else if (chan_req) begin
            win      = 4'b0010;
            win_type = CYC_CHAN;
        end else if (cca_req) begin
            win      = 4'b0100;
            win_type = CYC_CCA;
        end else if (ebox_req) begin
            win      = 4'b1000;
            win_type = CYC_EBOX;
        end
    end

endmodule

// File: rtl/mbox_cyc_arb.sv
// MBOX cycle arbiter: picks one of MB/CHAN/CCA/EBOX per MBOX cycle, pulses
// its grant for one cycle and holds BUSY until CSH reports cyc_done.
//   clk, rst_n : clock, async active-low reset
//   bus        : mbox_cyc_arb_if.slave (requests, cyc_done, err_clr in;
//                grants, cyc_active, cyc_type, starve_boost, timeout_err out)
// Optional watchdog: define MBOX_ARB_TIMEOUT_EN to abort BUSY after
// TIMEOUT_CYCLES cycles without cyc_done and flag timeout_err.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no cycle in progress; arbitrate any pending request
// ST_BUSY | cycle owned by cyc_type; grant pulsed on first cycle only
module mbox_cyc_arb
    import mbox_arb_pkg::*;
#(
    parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mbox_cyc_arb_if.slave bus
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    tMboxArbState    state_q, state_nxt;
    logic [3:0]      grant_q, grant_nxt;
    tMboxCycType     type_q, type_nxt;
    logic [SC_W-1:0] scnt_q, scnt_nxt;
    logic            boost_q, boost_nxt;
    logic            active_q, active_nxt;
    logic            err_q, err_nxt;

    logic            boost_now;
    logic [3:0]      win;
    tMboxCycType     win_type;
    logic            done_ok;
    logic            wd_expire;

    assign boost_now = (scnt_q == SC_W'(STARVE_LIMIT)) && bus.ebox_req;

    mbox_arb_prio u_prio (
        .mb_req   (bus.mb_req),
        .chan_req (bus.chan_req),
        .cca_req  (bus.cca_req),
        .ebox_req (bus.ebox_req),
        .boost    (boost_now),
        .win      (win),
        .win_type (win_type)
    );

    // grant_q is nonzero only in the grant cycle, where cyc_done is ignored
    assign done_ok = (state_q == ST_BUSY) && (grant_q == 4'b0000) && bus.cyc_done;

`ifdef MBOX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_nxt;

    // Down-counter loaded on grant; terminal count in BUSY is the last
    // permitted cycle, so BUSY lasts exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        wd_nxt = wd_q;
        if (state_q == ST_IDLE && win != 4'b0000)
            wd_nxt = WD_W'(TIMEOUT_CYCLES - 1);
        else if (state_q == ST_BUSY && wd_q != '0)
            wd_nxt = wd_q - 1'b1;
    end

    assign wd_expire = (state_q == ST_BUSY) && (wd_q == '0) && !done_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_nxt;
    end
`else
    // No watchdog; the parameter stays referenced so both builds share
    // one port/parameter list.
    assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nxt = state_q;
        grant_nxt = 4'b0000;
        type_nxt  = type_q;
        scnt_nxt  = scnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.ebox_req)
                    scnt_nxt = '0;
                if (win != 4'b0000) begin
                    state_nxt = ST_BUSY;
                    grant_nxt = win;
                    type_nxt  = win_type;
                    if (win[3])
                        scnt_nxt = '0;
                    else if ((win[1] || win[2]) && bus.ebox_req &&
                             scnt_q != SC_W'(STARVE_LIMIT))
                        scnt_nxt = scnt_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (done_ok || wd_expire)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        active_nxt = (state_nxt == ST_BUSY);
        boost_nxt  = (scnt_nxt == SC_W'(STARVE_LIMIT)) && bus.ebox_req;
        // a watchdog set beats a same-cycle clear
        if (wd_expire)
            err_nxt = 1'b1;
        else if (bus.err_clr)
            err_nxt = 1'b0;
        else
            err_nxt = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 4'b0000;
            type_q   <= CYC_MB;
            scnt_q   <= '0;
            boost_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            grant_q  <= grant_nxt;
            type_q   <= type_nxt;
            scnt_q   <= scnt_nxt;
            boost_q  <= boost_nxt;
            active_q <= active_nxt;
            err_q    <= err_nxt;
        end
    end

    assign bus.mb_grant     = grant_q[0];
    assign bus.chan_grant   = grant_q[1];
    assign bus.cca_grant    = grant_q[2];
    assign bus.ebox_grant   = grant_q[3];
    assign bus.cyc_active   = active_q;
    assign bus.cyc_type     = type_q;
    assign bus.starve_boost = boost_q;
    assign bus.timeout_err  = err_q;

endmodule

// File: doc/mbox_cyc_arb.md
# mbox_cyc_arb

Cycle arbiter for the KL10 MBOX cache/memory datapath. Four requesters compete for a single MBOX cycle: MB writeback, channel (CHAN), cache-clear/sweep (CCA) and EBOX. The block resolves fixed priority with EBOX anti-starvation, issues a one-cycle grant, and tracks the cycle until the cache control logic signals completion. It sits between the requester control logic and the CSH cycle sequencer, and it supplies the grant strobes the CSH interface consumes.

## Interface
- `STARVE_LIMIT`, default 4: consecutive non-EBOX grants allowed while `ebox_req` is pending.
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before a forced abort. Used only when the watchdog is compiled in.
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mb_req` in 1: MB writeback request, level.
- `chan_req` in 1: channel request, level.
- `cca_req` in 1: cache-clear/sweep request, level.
- `ebox_req` in 1: EBOX request, level.
- `cyc_done` in 1: CSH signals the end of the current cycle, one-cycle pulse.
- `err_clr` in 1: clears `timeout_err`.
- `mb_grant`, `chan_grant`, `cca_grant`, `ebox_grant` out 1 each: grant pulses, one-hot.
- `cyc_active` out 1: high throughout BUSY.
- `cyc_type` out 2: owner of the current or last cycle. MB=0, CHAN=1, CCA=2, EBOX=3.
- `starve_boost` out 1: EBOX promotion is in effect for the next arbitration.
- `timeout_err` out 1: sticky watchdog error.

## Operation
- States: IDLE and BUSY.
- **IDLE.** If any request is high, register the winner's grant and go to BUSY. Otherwise stay in IDLE.
- **Normal priority:** MB > CHAN > CCA > EBOX.
- **Boost.** When the starvation counter equals `STARVE_LIMIT` and `ebox_req` is high, `starve_boost`=1 and the order becomes MB > EBOX > CHAN > CCA. MB is never preempted.
- **Starvation counter** (width is `$clog2(STARVE_LIMIT+1)`, saturating):
  - Increments on each CHAN or CCA grant issued while `ebox_req` is high.
  - Clears on an EBOX grant.
  - Clears whenever `ebox_req` is low in IDLE.
  - MB grants do not change it.
- **Grant pulse.** The grant is high only in the first BUSY cycle. `cyc_type` is loaded in the same cycle and holds until the next grant.
- **Request handshake.** A requester drops its `req` in the cycle after it sees its grant. A `req` still high when the arbiter returns to IDLE counts as a new request.
- **BUSY.**
  - `cyc_done` is ignored in the grant cycle.
  - From the second BUSY cycle onward, `cyc_done`=1 moves the arbiter to IDLE on the next edge.
- **Simultaneous events.** If `cyc_done` and `err_clr` arrive in the same cycle, both take effect. If `cyc_done` and a watchdog expiry land on the same edge, `cyc_done` wins: normal completion, no error.
- **`timeout_err`.** Set by the watchdog. Cleared by `err_clr`, unless the set and the clear arrive in the same cycle, in which case set wins. Arbitration continues while the error is set.
- **Reset** is legal mid-cycle. It returns the arbiter to IDLE immediately, without waiting for `cyc_done`.

## Timing
- **Reset values:**
  - All grants 0.
  - `cyc_active`=0.
  - `cyc_type`=0.
  - `starve_boost`=0.
  - `timeout_err`=0.
  - State IDLE.
  - Counters 0.
- **Latency:** a request sampled at edge N produces a grant visible after edge N (cycle N+1).
- **Minimum cycle:** 2 BUSY cycles.
- **Back-to-back spacing:** one IDLE cycle between cycles. The earliest re-grant is 2 edges after `cyc_done` is sampled.
- **Outputs:** all registered; no combinational path from input to output.

## Configuration
- `MBOX_ARB_TIMEOUT_EN` defined:
  - A BUSY cycle counter runs, cleared on every grant.
  - When the counter reaches `TIMEOUT_CYCLES` without `cyc_done`, the arbiter forces IDLE and sets `timeout_err`.
- `MBOX_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `timeout_err` is tied to 0.
  - BUSY lasts until `cyc_done`, however long that takes.

## Structure
- **Package `mbox_arb_pkg`:**
  - enum `tMboxCycType` (MB, CHAN, CCA, EBOX).
  - enum `tMboxArbState` (IDLE, BUSY).
  - Default localparams for `STARVE_LIMIT` and `TIMEOUT_CYCLES`.
- **Sub-module `mbox_arb_prio`:** combinational priority resolver. Inputs are the 4 requests and `starve_boost`; output is a one-hot winner plus `tMboxCycType`.
- **Parent:** holds the FSM, the counters and the output registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-BUSY -> all outputs are at reset values immediately. After release with no requests, `cyc_active`=0.
- **Contention:** raise all 4 requests together, 1 cycle before release -> grant order MB, CHAN, CCA, EBOX. Each requester drops its `req` after its grant. Each cycle ends with `cyc_done` on BUSY cycle 3.
- **Starvation:** hold `ebox_req` and `chan_req` continuously with `STARVE_LIMIT`=4 -> 4 CHAN grants, then `starve_boost`=1 and an EBOX grant, then the counter reads 0.
- **MB priority under boost:** with boost active, raise `mb_req` -> MB is granted first, EBOX next.
- **Early `cyc_done`:** pulse `cyc_done` in the grant cycle -> it is ignored; the arbiter stays BUSY until a second pulse.
- **Watchdog, with `MBOX_ARB_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=8:** withhold `cyc_done` -> IDLE after 8 BUSY cycles with `timeout_err`=1; `err_clr` clears it.
